fpadd_issue_stage: RTL and testbench

- Sequential wrapper around the team's combinational FP32 adder.
- Accepts tagged operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Drives the head pair onto the adder inputs, resolves IEEE special cases locally, and registers the result onto a valid/ready output stream.
- Sits directly upstream and downstream of the adder: it feeds `a`/`b` and consumes `res`.

---
 rtl/fpadd_pkg.sv | 41 ++++
 rtl/fpadd_special.sv | 43 ++++
 rtl/fpadd_issue_stage.sv | 138 +++++++++++++
 tb/tb_fpadd_issue_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared FP32 types, constants and classification helpers for the adder wrapper.
package fpadd_pkg;

    // IEEE-754 single precision field layout.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.mant != 23'h0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.mant == 23'h0);
    endfunction

    function automatic logic is_zero(input fp32_t x);
        return (x.exp == 8'h00) && (x.mant == 23'h0);
    endfunction

    function automatic logic is_denorm(input fp32_t x);
        return (x.exp == 8'h00) && (x.mant != 23'h0);
    endfunction

    // Denormals collapse to a zero of the same sign; everything else passes through.
    function automatic fp32_t flush_denorm(input fp32_t x);
        fp32_t r;
        r = x;
        if (is_denorm(x)) begin
            r.exp  = 8'h00;
            r.mant = 23'h0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fpadd_special.sv
// Combinational special-case resolver: picks between IEEE special results and
// the external adder's sum for an already-flushed operand pair.
module fpadd_special
    import fpadd_pkg::*;
(
    input  fp32_t       a,
    input  fp32_t       b,
    input  logic        any_flushed,
    input  logic [31:0] add_res,
    output logic [31:0] res,
    output logic        special
);

    // Rules are prioritised top to bottom; the adder result is the fallback and is
    // still marked special when a denormal had to be flushed to reach it.
    always_comb begin
        res     = add_res;
        special = any_flushed;
        if (is_nan(a) || is_nan(b)) begin
            res     = FP_QNAN;
            special = 1'b1;
        end else if (is_inf(a) && is_inf(b) && (a.sign != b.sign)) begin
            res     = FP_QNAN;
            special = 1'b1;
        end else if (is_inf(a) && !is_inf(b)) begin
            res     = a;
            special = 1'b1;
        end else if (is_inf(b) && !is_inf(a)) begin
            res     = b;
            special = 1'b1;
        end else if (is_zero(a) && is_zero(b)) begin
            res     = {a.sign & b.sign, 31'h0};
            special = 1'b1;
        end else if (is_zero(a)) begin
            res     = b;
            special = 1'b1;
        end else if (is_zero(b)) begin
            res     = a;
            special = 1'b1;
        end
    end

endmodule

// File: rtl/fpadd_issue_stage.sv
// Issue stage around the combinational FP32 adder: buffers tagged operand pairs
// in a small FIFO, presents the head pair to the adder, and registers the
// resolved sum onto a valid/ready output stream in acceptance order.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module fpadd_issue_stage
    import fpadd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    input  logic [31:0]            add_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_res,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_special,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fp32_t            mem_a   [DEPTH];
    fp32_t            mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic        push;
    logic        pop;
    logic        head_valid;
    fp32_t       head_a;
    fp32_t       head_b;
    fp32_t       flush_a;
    fp32_t       flush_b;
    logic        any_flushed;
    logic [31:0] sel_res;
    logic        sel_special;

    // Readiness depends only on stored occupancy, never on out_ready, so the
    // input handshake has no combinational path from downstream.
    assign in_ready   = (count < FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign head_valid = (count != '0);
    assign pop        = head_valid && (!out_valid || out_ready);

    assign head_a      = mem_a[rd_ptr];
    assign head_b      = mem_b[rd_ptr];
    assign flush_a     = flush_denorm(head_a);
    assign flush_b     = flush_denorm(head_b);
    assign any_flushed = is_denorm(head_a) || is_denorm(head_b);

    // The adder only ever sees flushed operands, and a quiet zero when there is no head.
    always_comb begin
        add_a = 32'h0;
        add_b = 32'h0;
        if (head_valid) begin
            add_a = flush_a;
            add_b = flush_b;
        end
    end

    fpadd_special u_special (
        .a           (flush_a),
        .b           (flush_b),
        .any_flushed (any_flushed),
        .add_res     (add_res),
        .res         (sel_res),
        .special     (sel_special)
    );

    // Operand storage; contents are meaningless outside the occupied window so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= fp32_t'(in_a);
            mem_b[wr_ptr]   <= fp32_t'(in_b);
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // Read and write pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy tracks the FIFO only; a simultaneous push and pop cancels out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register: load on pop, drop valid when consumed without a refill,
    // otherwise hold steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_res     <= 32'h0;
            out_tag     <= '0;
            out_special <= 1'b0;
        end else if (pop) begin
            out_valid   <= 1'b1;
            out_res     <= sel_res;
            out_tag     <= mem_tag[rd_ptr];
            out_special <= sel_special;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpadd_issue_stage.sv
// Self-checking bench for fpadd_issue_stage: a behavioural FP32 adder drives
// add_res, and a queue-based reference model predicts every output transaction.
module tb_fpadd_issue_stage;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             special;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_a;
    logic [31:0]            in_b;
    logic [TAG_W-1:0]       in_tag;
    logic [31:0]            add_a;
    logic [31:0]            add_b;
    logic [31:0]            add_res;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_res;
    logic [TAG_W-1:0]       out_tag;
    logic                   out_special;
    logic [$clog2(DEPTH):0] count;

    int   checks = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    logic last_push;
    logic hold_pending = 1'b0;
    logic [31:0]      held_res;
    logic [TAG_W-1:0] held_tag;
    logic             held_special;

    always #5 clk = ~clk;

    fpadd_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_res     (add_res),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_tag     (out_tag),
        .out_special (out_special),
        .count       (count)
    );

    // Truncating FP32 adder for normal operands; zeros/denormals act as zero.
    function automatic logic [31:0] fp_add_model(input logic [31:0] x_in, input logic [31:0] y_in);
        logic [31:0] x;
        logic [31:0] y;
        logic [27:0] mx;
        logic [27:0] my;
        logic [27:0] s;
        int ex;
        int ey;
        int d;
        if (x_in[30:23] == 8'hFF || y_in[30:23] == 8'hFF) begin
            if ((x_in[30:23] == 8'hFF && x_in[22:0] != 0) || (y_in[30:23] == 8'hFF && y_in[22:0] != 0))
                return QNAN;
            if (x_in[30:23] == 8'hFF && y_in[30:23] == 8'hFF)
                return (x_in[31] == y_in[31]) ? x_in : QNAN;
            return (x_in[30:23] == 8'hFF) ? x_in : y_in;
        end
        if (x_in[30:23] == 8'h00 && y_in[30:23] == 8'h00) return {x_in[31] & y_in[31], 31'h0};
        if (x_in[30:23] == 8'h00) return y_in;
        if (y_in[30:23] == 8'h00) return x_in;
        if (x_in[30:0] >= y_in[30:0]) begin
            x = x_in;
            y = y_in;
        end else begin
            x = y_in;
            y = x_in;
        end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        d  = ex - ey;
        mx = {2'b01, x[22:0], 3'b000};
        my = {2'b01, y[22:0], 3'b000};
        my = (d >= 28) ? 28'h0 : (my >> d);
        if (x[31] == y[31]) begin
            s = mx + my;
            if (s[27]) begin
                s  = s >> 1;
                ex = ex + 1;
            end
            if (ex >= 255) return {x[31], 8'hFF, 23'h0};
        end else begin
            s = mx - my;
            if (s == 28'h0) return 32'h0;
            while (!s[26] && ex > 1) begin
                s  = s << 1;
                ex = ex - 1;
            end
            if (!s[26]) return {x[31], 31'h0};
        end
        return {x[31], 8'(ex), s[25:3]};
    endfunction

    always_comb add_res = fp_add_model(add_a, add_b);

    function automatic logic f_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic logic f_inf(input logic [31:0] x);
        return x[30:0] == 31'h7F80_0000;
    endfunction

    function automatic logic f_zero(input logic [31:0] x);
        return x[30:0] == 31'h0;
    endfunction

    // Expected transaction straight from the result-selection rules.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        exp_t        e;
        logic [31:0] fa;
        logic [31:0] fb;
        logic        flushed;
        fa = a;
        fb = b;
        flushed = 1'b0;
        if (a[30:23] == 8'h00 && a[22:0] != 0) begin fa = {a[31], 31'h0}; flushed = 1'b1; end
        if (b[30:23] == 8'h00 && b[22:0] != 0) begin fb = {b[31], 31'h0}; flushed = 1'b1; end
        e.tag = t;
        e.special = 1'b1;
        if (f_nan(fa) || f_nan(fb))                          e.res = QNAN;
        else if (f_inf(fa) && f_inf(fb) && fa[31] != fb[31]) e.res = QNAN;
        else if (f_inf(fa) != f_inf(fb))                     e.res = f_inf(fa) ? fa : fb;
        else if (f_zero(fa) && f_zero(fb))                   e.res = {fa[31] & fb[31], 31'h0};
        else if (f_zero(fa) != f_zero(fb))                   e.res = f_zero(fa) ? fb : fa;
        else begin
            e.res     = fp_add_model(fa, fb);
            e.special = flushed;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 9))
            0:       return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 31'h0};
            3:       return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
            default: return {s, 8'($urandom_range(120, 135)), 23'($urandom)};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_push = 1'b0;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_res", out_res, held_res);
                checkOutput("hold_tag", 32'(out_tag), 32'(held_tag));
                checkOutput("hold_special", 32'(out_special), 32'(held_special));
            end
            hold_pending = out_valid && !out_ready;
            held_res     = out_res;
            held_tag     = out_tag;
            held_special = out_special;
            if (out_valid && out_ready) begin
                checkOutput("result_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("sb_res", out_res, e.res);
                    checkOutput("sb_tag", 32'(out_tag), 32'(e.tag));
                    checkOutput("sb_special", 32'(out_special), 32'(e.special));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_a, in_b, in_tag));
                last_push = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        applyStimulus(1'b1, a, b, t);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_push) break;
        end
        checkOutput("accept_timeout", 32'(last_push), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
    endtask

    // Push a pair, then check the registered result one edge later.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, input logic [31:0] exp_res, input logic exp_special);
        send_pair(a, b, t);
        checkOutput({name, "_not_early"}, 32'(out_valid), 32'd0);
        tick();
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_res"}, out_res, exp_res);
        checkOutput({name, "_tag"}, 32'(out_tag), 32'(t));
        checkOutput({name, "_special"}, 32'(out_special), 32'(exp_special));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_res", out_res, 32'h0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        checkOutput("rst_out_special", 32'(out_special), 32'd0);
        checkOutput("rst_add_a", add_a, 32'h0);
        rst = 1'b0;

        $display("[TB] directed pairs");
        out_ready = 1'b1;
        directed("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 1'b0);
        directed("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 4'd1, 32'h7FC0_0000, 1'b1);
        directed("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 4'd2, 32'h7FC0_0000, 1'b1);
        directed("negz_negz", 32'h8000_0000, 32'h8000_0000, 4'd4, 32'h8000_0000, 1'b1);
        directed("negz_posz", 32'h8000_0000, 32'h0000_0000, 4'd5, 32'h0000_0000, 1'b1);
        directed("denorm_one", 32'h0000_0001, 32'h3F80_0000, 4'd6, 32'h3F80_0000, 1'b1);
        tick();
        tick();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            applyStimulus(1'b1, rand_operand(), rand_operand(), 4'(t));
            tick();
            checkOutput("bp_accept", 32'(last_push), 32'd1);
        end
        applyStimulus(1'b1, rand_operand(), rand_operand(), 4'd5);
        tick();
        tick();
        checkOutput("bp_count_full", 32'(count), 32'd4);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_head_tag", 32'(out_tag), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("bp_stream_valid", 32'(out_valid), 32'd1);
            tick();
            if (last_push) applyStimulus(1'b0, 32'h0, 32'h0, '0);
        end
        checkOutput("bp_drained_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_drained_count", 32'(count), 32'd0);

        $display("[TB] steady-state streaming");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, rand_operand(), rand_operand(), 4'(i));
            tick();
            checkOutput("ss_accept", 32'(last_push), 32'd1);
            if (i >= 1) begin
                checkOutput("ss_count", 32'(count), 32'd1);
                checkOutput("ss_no_bubble", 32'(out_valid), 32'd1);
            end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        tick();
        tick();

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom), rand_operand(), rand_operand(), 4'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checkOutput("rand_drained_count", 32'(count), 32'd0);

        $display("[TB] reset with data in flight");
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, rand_operand(), rand_operand(), 4'(t + 8));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h3F80_0000, 32'h3F80_0000, 4'd15);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, '0);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("post_rst_count", 32'(count), 32'd0);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("no_stale_result", 32'(out_valid), 32'd0);
        end

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
